spi_const_seq_master: RTL and testbench

//  SPI master that plays a compile-time table of N_PACKETS words (N_BITS each) to one of N_CS slaves.

---
 rtl/spi_const_seq_master.sv | 216 +++++++++++++++++++++
 tb/tb_spi_const_seq_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_const_seq_master.sv
// spi_const_seq_master: plays a compile-time table of N_PACKETS words, each N_BITS
// wide, MSB first on an SPI bus (CPHA=0). Each packet is routed to one of N_CS chip
// selects. The table runs once after reset when AUTO_START=1, and again on each
// start pulse received while idle.
// Optional feature: define SPI_READBACK_EN to capture spi_miso on every leading SCK
// edge. Each captured word is reported on rd_data/rd_idx with a one-cycle rd_valid.
module spi_const_seq_master #(
  parameter int CLK_DIV    = 6,
  parameter int N_BITS     = 16,
  parameter int N_PACKETS  = 2,
  parameter int N_CS       = 1,
  localparam int CSW       = (N_CS > 1) ? $clog2(N_CS) : 1,
  localparam int CNTW      = (N_PACKETS > 1) ? $clog2(N_PACKETS) : 1,
  parameter logic [N_BITS*N_PACKETS-1:0] DATA   = '0,
  parameter logic [N_PACKETS*CSW-1:0]    CS_MAP = '0,
  parameter bit CPOL       = 1'b0,
  parameter int GAP_CYCLES = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic [N_CS-1:0]   spi_ncs,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [N_BITS-1:0] rd_data,
  output logic [CNTW-1:0]   rd_idx,
  output logic              rd_valid
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_DONE} state_t;

  // One counter serves both the SCK half-period and the inter-packet gap.
  localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [CW-1:0]   DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(N_BITS - 1);
  localparam logic [CNTW-1:0] PKT_LAST = CNTW'(N_PACKETS - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              act_q, act_d;     // 1 while in the active (~CPOL) SCK half
  logic [CNTW-1:0]   pkt_q, pkt_d;
  logic [N_BITS-1:0] tx_q, tx_d;
  logic              auto_q, auto_d;   // pending power-on run
  logic              sck_d, mosi_d, busy_d, done_d;
  logic [N_CS-1:0]   ncs_d;
  logic              lead_edge;        // SCK goes active on this clock edge
  logic              shift_end;        // last bit of a packet finishes on this edge

  function automatic logic [N_BITS-1:0] word_of(input logic [CNTW-1:0] p);
    return DATA[int'(p)*N_BITS +: N_BITS];
  endfunction

  // Chip-select slots that point past N_CS leave every line high.
  function automatic logic [N_CS-1:0] ncs_of(input logic [CNTW-1:0] p);
    logic [CSW-1:0] sel;
    ncs_of = '1;
    sel    = CS_MAP[int'(p)*CSW +: CSW];
    for (int i = 0; i < N_CS; i++)
      if (int'(sel) == i) ncs_of[i] = 1'b0;
  endfunction

  // Next-state logic and next values of the registered bus outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    act_d     = act_q;
    pkt_d     = pkt_q;
    tx_d      = tx_q;
    auto_d    = auto_q;
    lead_edge = 1'b0;
    shift_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          pkt_d   = '0;
          tx_d    = word_of('0);
          auto_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d   = S_SHIFT;
          cnt_d     = '0;
          bit_d     = '0;
          act_d     = 1'b1;
          lead_edge = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (act_q) begin
            // Trailing edge: present the next bit; the last bit is held through
            // its idle half, which serves as the chip-select hold time.
            act_d = 1'b0;
            if (bit_q != BIT_LAST) tx_d = tx_q << 1;
          end else if (bit_q == BIT_LAST) begin
            state_d   = S_GAP;
            shift_end = 1'b1;
          end else begin
            act_d     = 1'b1;
            bit_d     = bit_q + 1'b1;
            lead_edge = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (pkt_q == PKT_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            pkt_d   = pkt_q + 1'b1;
            tx_d    = word_of(pkt_q + 1'b1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pkt_d   = '0;
        bit_d   = '0;
        act_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    sck_d  = (state_d == S_SHIFT && act_d) ? ~CPOL : CPOL;
    if (state_d == S_SETUP || state_d == S_SHIFT) begin
      ncs_d  = ncs_of(pkt_d);
      mosi_d = tx_d[N_BITS-1];
    end else begin
      ncs_d  = '1;
      mosi_d = 1'b0;
    end
  end

  // State, counters and registered bus outputs; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      act_q    <= 1'b0;
      pkt_q    <= '0;
      tx_q     <= '0;
      auto_q   <= AUTO_START;
      spi_clk  <= CPOL;
      spi_ncs  <= '1;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      act_q    <= act_d;
      pkt_q    <= pkt_d;
      tx_q     <= tx_d;
      auto_q   <= auto_d;
      spi_clk  <= sck_d;
      spi_ncs  <= ncs_d;
      spi_mosi <= mosi_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef SPI_READBACK_EN
  logic [N_BITS-1:0] rx_q;

  // MISO capture on each leading SCK edge; the word is published when SHIFT ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q     <= '0;
      rd_data  <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= shift_end;
      if (lead_edge) rx_q <= (rx_q << 1) | N_BITS'(spi_miso);
      if (shift_end) begin
        rd_data <= rx_q;
        rd_idx  <= pkt_q;
      end
    end
  end
`else
  logic [2:0] unused_rb;
  assign unused_rb = {spi_miso, lead_edge, shift_end};
  assign rd_data   = '0;
  assign rd_idx    = '0;
  assign rd_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_const_seq_master.sv
// Bench for spi_const_seq_master: two instances (single-slave CPOL=0 auto-start;
// three-slave CPOL=1 start-driven) compared each cycle against an arithmetic
// timeline model of the bus derived from packet/bit/half-period positions.
module tb_spi_const_seq_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic miso_a = 1'b0, miso_b = 1'b0;

  always #5 clk = ~clk;

  logic        sck_a, mosi_a, busy_a, done_a, rdv_a;
  logic [0:0]  ncs_a;
  logic [15:0] rdd_a;
  logic [0:0]  rdi_a;
  logic        sck_b, mosi_b, busy_b, done_b, rdv_b;
  logic [2:0]  ncs_b;
  logic [7:0]  rdd_b;
  logic [1:0]  rdi_b;

  spi_const_seq_master #(
    .CLK_DIV(6), .N_BITS(16), .N_PACKETS(2), .N_CS(1),
    .DATA(32'h0080_010F), .CS_MAP(2'b00), .CPOL(1'b0),
    .GAP_CYCLES(4), .AUTO_START(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .spi_clk(sck_a), .spi_ncs(ncs_a), .spi_mosi(mosi_a), .spi_miso(miso_a),
    .rd_data(rdd_a), .rd_idx(rdi_a), .rd_valid(rdv_a)
  );

  spi_const_seq_master #(
    .CLK_DIV(2), .N_BITS(8), .N_PACKETS(3), .N_CS(3),
    .DATA(24'h3C_5A_A5), .CS_MAP(6'b11_00_10), .CPOL(1'b1),
    .GAP_CYCLES(3), .AUTO_START(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .spi_clk(sck_b), .spi_ncs(ncs_b), .spi_mosi(mosi_b), .spi_miso(miso_b),
    .rd_data(rdd_b), .rd_idx(rdi_b), .rd_valid(rdv_b)
  );

`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic        sck;
    logic [3:0]  ncs;
    logic        mosi;
    logic        busy;
    logic        done;
    logic        rv;
    logic [1:0]  ri;
    logic [15:0] rd;
  } obs_t;

  // Table contents and chip-select routing as configured on each instance.
  logic [15:0] TW  [2][3] = '{'{16'h010F, 16'h0080, 16'h0000}, '{16'h00A5, 16'h005A, 16'h003C}};
  int          TCS [2][3] = '{'{0, 0, 0}, '{2, 0, 3}};
  logic [15:0] RXW [2][3];        // words the MISO slave returns
  logic [15:0] exp_rd [2];
  logic [1:0]  exp_ri [2];

  int cmp_cnt = 0;
  int err_cnt = 0;

  // MISO slave for instance A: new word per ncs-low window, next bit after each leading edge.
  int   sl_pkt = 0, sl_bit = 0;
  logic prev_ncs = 1'b1, prev_sck = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      sl_pkt = 0;
      sl_bit = 0;
    end else begin
      if (prev_ncs && !ncs_a[0]) sl_bit = 0;
      else if (!ncs_a[0] && !prev_sck && sck_a) sl_bit = sl_bit + 1;
      if (!prev_ncs && ncs_a[0]) sl_pkt = sl_pkt + 1;
    end
    prev_ncs = ncs_a[0];
    prev_sck = sck_a;
    miso_a = (sl_pkt < 2 && sl_bit < 16) ? RXW[0][sl_pkt][15 - sl_bit] : 1'b0;
  end

  function automatic obs_t get_obs(input int sel);
    obs_t x;
    if (sel == 0) begin
      x.sck = sck_a; x.ncs = {3'b111, ncs_a}; x.mosi = mosi_a; x.busy = busy_a;
      x.done = done_a; x.rv = rdv_a; x.ri = {1'b0, rdi_a}; x.rd = rdd_a;
    end else begin
      x.sck = sck_b; x.ncs = {1'b1, ncs_b}; x.mosi = mosi_b; x.busy = busy_b;
      x.done = done_b; x.rv = rdv_b; x.ri = rdi_b; x.rd = {8'h00, rdd_b};
    end
    return x;
  endfunction

  function automatic int seq_len(input int sel);
    int cd, nb, np, gap;
    cd = sel ? 2 : 6; nb = sel ? 8 : 16; np = sel ? 3 : 2; gap = sel ? 3 : 4;
    return np * (cd * (1 + 2 * nb) + gap);
  endfunction

  // Expected bus state o cycles after the first SETUP cycle (o<0: idle).
  function automatic obs_t model(input int sel, input int o, output bit mchk);
    obs_t e;
    int cd, nb, np, gap, ncsn, L, P, T, k, r, b;
    logic cpol;
    cd = sel ? 2 : 6; nb = sel ? 8 : 16; np = sel ? 3 : 2; gap = sel ? 3 : 4;
    ncsn = sel ? 3 : 1; cpol = sel ? 1'b1 : 1'b0;
    L = cd * (1 + 2 * nb); P = L + gap; T = np * P;
    mchk = 1'b1;
    e.sck = cpol; e.ncs = 4'hF; e.mosi = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    e.rv = 1'b0; e.ri = exp_ri[sel]; e.rd = exp_rd[sel];
    if (o >= 0 && o < T) begin
      k = o / P; r = o % P; e.busy = 1'b1;
      if (r < L) begin
        if (TCS[sel][k] < ncsn) e.ncs[TCS[sel][k]] = 1'b0;
        if (r < cd) begin
          e.mosi = TW[sel][k][nb - 1];
        end else begin
          b = (r - cd) / (2 * cd);
          if (((r - cd) / cd) % 2 == 0) begin
            e.sck  = ~cpol;
            e.mosi = TW[sel][k][nb - 1 - b];
          end else begin
            mchk = 1'b0;
          end
        end
      end else if (r == L && RB) begin
        e.rv = 1'b1; e.ri = 2'(k); e.rd = RXW[sel][k];
      end
    end else if (o == T) begin
      e.busy = 1'b1; e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic void clear_rd_model();
    exp_rd[0] = '0; exp_rd[1] = '0; exp_ri[0] = '0; exp_ri[1] = '0;
  endfunction

  // Compare instance sel from its first SETUP cycle onward; optionally pulse start
  // at offset start_at, or assert reset right after offset abort_at.
  task automatic check_seq(input int sel, input int start_at, input int extra,
                           input int abort_at, input string name);
    obs_t e, a, m;
    bit mchk;
    int T;
    T = seq_len(sel);
    for (int o = 0; o <= T + extra; o++) begin
      @(negedge clk);
      e = model(sel, o, mchk);
      a = get_obs(sel);
      m = '1;
      if (!mchk) m.mosi = 1'b0;
      cmp_cnt++;
      if ((a & m) !== (e & m)) begin
        err_cnt++;
        $display("FAIL %s dut%0d o=%0d got=%h expected=%h", name, sel, o, a & m, e & m);
      end
      if (e.rv) begin exp_rd[sel] = e.rd; exp_ri[sel] = e.ri; end
      if (sel == 1) start_b = (o == start_at);
      if (o == abort_at) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    obs_t e, a;
    bit mchk;
    reset = 1'b0;
    clear_rd_model();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      e = model(s, -1, mchk);
      a = get_obs(s);
      cmp_cnt++;
      if (a !== e) begin
        err_cnt++;
        $display("FAIL reset_state dut%0d got=%h expected=%h", s, a, e);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_auto_start();
    check_seq(0, -1, 8, -1, "auto_start");
  endtask

  task automatic test_idle_no_start();
    obs_t e, a;
    bit mchk;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      e = model(1, -1, mchk);
      a = get_obs(1);
      cmp_cnt++;
      if (a !== e) begin
        err_cnt++;
        $display("FAIL idle_no_start cyc=%0d got=%h expected=%h", i, a, e);
      end
    end
  endtask

  task automatic test_start_while_busy();
    @(negedge clk) start_b = 1'b1;
    check_seq(1, int'($urandom_range(seq_len(1) - 1, 1)), 6, -1, "start_while_busy");
  endtask

  task automatic test_start_in_done();
    @(negedge clk) start_b = 1'b1;
    check_seq(1, seq_len(1), 6, -1, "start_in_done");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk) start_b = 1'b1;
      check_seq(1, -1, int'($urandom_range(4, 1)), -1, "replay");
    end
  endtask

  task automatic test_reset_abort();
    obs_t e, a;
    bit mchk;
    RXW[0][0] = 16'($urandom); RXW[0][1] = 16'($urandom);
    @(negedge clk) reset = 1'b0;
    clear_rd_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // Bit 5 of packet 0 sits at offset CLK_DIV + 5*2*CLK_DIV.
    check_seq(0, -1, 0, 66, "pre_abort");
    #1;
    clear_rd_model();
    e = model(0, -1, mchk);
    a = get_obs(0);
    cmp_cnt++;
    if (a !== e) begin
      err_cnt++;
      $display("FAIL reset_abort_same_cycle got=%h expected=%h", a, e);
    end
    repeat (3) @(negedge clk);
    RXW[0][0] = 16'($urandom); RXW[0][1] = 16'($urandom);
    reset = 1'b1;
    check_seq(0, -1, 8, -1, "restart_after_abort");
  endtask

  initial begin
    RXW[0][0] = 16'hBEEF; RXW[0][1] = 16'h1234; RXW[0][2] = '0;
    RXW[1][0] = '0; RXW[1][1] = '0; RXW[1][2] = '0;
    test_reset();
    test_auto_start();
    test_idle_no_start();
    test_start_while_busy();
    test_start_in_done();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
